// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: NOP encoding, fetch FSM state type/constants, default reset PC.
package pipeline_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t REQ  = 2'd0;
    localparam fetch_state_t WAIT = 2'd1;
    localparam fetch_state_t HOLD = 2'd2;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bundle between the fetch stage (master) and memory (slave).
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  InstrReq;
    logic [DATA_WIDTH-1:0] InstrAddr;
    logic                  InstrAck;
    logic [DATA_WIDTH-1:0] InstrRdata;

    modport master (
        output InstrReq,
        output InstrAddr,
        input  InstrAck,
        input  InstrRdata
    );

    modport slave (
        input  InstrReq,
        input  InstrAddr,
        output InstrAck,
        output InstrRdata
    );

endinterface

// File: rtl/fetch_decode.sv
// IF/ID pipeline register with stall and flush; flush wins over stall, an unstalled cycle
// without a load inserts a bubble so decode never sees the same instruction twice.
module fetch_decode
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] pcplus4_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pcplus4_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pcplus4_q;
    logic                  valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= DATA_WIDTH'(NOP);
            pc_q      <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else if (flush_i) begin
            instr_q <= DATA_WIDTH'(NOP);
            valid_q <= 1'b0;
        end else if (!stall_i) begin
            if (load_i) begin
                instr_q   <= instr_i;
                pc_q      <= pc_i;
                pcplus4_q <= pcplus4_i;
                valid_q   <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: REQ/WAIT/HOLD FSM, PCF, redirect/kill of in-flight requests, stall buffer.
// Optional FETCH_PERF_EN adds FetchWaitCount (cycles spent in WAIT or HOLD).
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    fetch_stage_if.master         imem,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] pcD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD,
    output logic                  FetchBusy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           FetchWaitCount
`endif
);

    localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pcf_q, pcf_d;
    logic [DATA_WIDTH-1:0] redirect_q, redirect_d;
    logic                  kill_q, kill_d;
    logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [DATA_WIDTH-1:0] hold_pc_q, hold_pc_d;

    logic                  id_load;
    logic [DATA_WIDTH-1:0] id_instr;
    logic [DATA_WIDTH-1:0] id_pc;
    logic                  req;

    assign req            = (state_q != HOLD);
    assign imem.InstrReq  = req;
    assign imem.InstrAddr = pcf_q;
    assign FetchBusy      = req & ~imem.InstrAck;

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        redirect_d   = redirect_q;
        kill_d       = kill_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        id_load      = 1'b0;
        id_instr     = imem.InstrRdata;
        id_pc        = pcf_q;

        case (state_q)
            REQ, WAIT: begin
                if (imem.InstrAck) begin
                    state_d = REQ;
                    kill_d  = 1'b0;
                    if (PCSrcE) begin
                        pcf_d = PCTargetE;
                    end else if (kill_q) begin
                        pcf_d = redirect_q;
                    end else if (FlushD) begin
                        // word dropped, PCF kept so the same address is fetched again
                    end else if (StallD) begin
                        hold_instr_d = imem.InstrRdata;
                        hold_pc_d    = pcf_q;
                        pcf_d        = pcf_q + FOUR;
                        state_d      = HOLD;
                    end else begin
                        id_load = 1'b1;
                        pcf_d   = pcf_q + FOUR;
                    end
                end else begin
                    state_d = WAIT;
                    if (PCSrcE) begin
                        redirect_d = PCTargetE;
                        kill_d     = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    state_d = REQ;
                end else if (FlushD) begin
                    state_d = REQ;
                end else if (!StallD) begin
                    id_load  = 1'b1;
                    id_instr = hold_instr_q;
                    id_pc    = hold_pc_q;
                    state_d  = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            pcf_q        <= RESET_PC;
            redirect_q   <= '0;
            kill_q       <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            redirect_q   <= redirect_d;
            kill_q       <= kill_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    fetch_decode #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fetch_decode (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (StallD),
        .flush_i   (FlushD),
        .load_i    (id_load),
        .instr_i   (id_instr),
        .pc_i      (id_pc),
        .pcplus4_i (id_pc + FOUR),
        .instr_o   (InstrD),
        .pc_o      (pcD),
        .pcplus4_o (PCPlus4D),
        .valid_o   (ValidD)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] wait_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT || state_q == HOLD) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    assign FetchWaitCount = wait_cnt_q;
`endif

endmodule
